// File: rtl/drac_pkg.sv
// Shared rename-stage types: checkpoint sizing, label type and the
// checkpoint controller state encoding.
package drac_pkg;

  localparam int NUM_CHECKPOINTS = 4;
  localparam int CKPT_W          = $clog2(NUM_CHECKPOINTS);

  typedef logic [CKPT_W-1:0] checkpoint_ptr;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECOVER,
    ST_REC_BLANK,
    ST_EXC_DRAIN,
    ST_EXC_RECOVER
  } rename_ckpt_state_t;

endpackage

// File: rtl/rename_ckpt_ctrl_age_cmp.sv
// Age comparator for checkpoint labels: older is high when a was allocated
// before b, with ages measured from the tail checkpoint.
module ckpt_age_cmp #(
  parameter int CKPT_W = 2
) (
  input  logic [CKPT_W-1:0] a,
  input  logic [CKPT_W-1:0] b,
  input  logic [CKPT_W-1:0] tail,
  output logic              older
);
  import drac_pkg::*;

  logic [CKPT_W-1:0] age_a;
  logic [CKPT_W-1:0] age_b;

  assign age_a = a - tail;
  assign age_b = b - tail;
  assign older = age_a < age_b;

endmodule

// File: rtl/rename_ckpt_ctrl.sv
// Checkpoint sequencing for the rename table: grants/frees checkpoints,
// drives mispredict and exception recovery, and stalls rename meanwhile.
module rename_ckpt_ctrl #(
  parameter int NUM_CHECKPOINTS = drac_pkg::NUM_CHECKPOINTS,
  parameter int CKPT_W          = $clog2(NUM_CHECKPOINTS)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              rename_valid_i,
  input  logic              rename_is_branch_i,
  input  logic              br_valid_i,
  input  logic              br_mispredict_i,
  input  logic [CKPT_W-1:0] br_checkpoint_i,
  input  logic              commit_branch_i,
  input  logic              exc_flush_i,
  input  logic              rob_empty_i,
  output logic              do_checkpoint_o,
  output logic              do_recover_o,
  output logic [CKPT_W-1:0] recover_checkpoint_o,
  output logic              delete_checkpoint_o,
  output logic              recover_commit_o,
  output logic              stall_rename_o,
  output logic              flush_front_o,
  output logic [CKPT_W-1:0] ckpt_label_o
);
  import drac_pkg::*;

  // Handshake: every request input is a single-cycle qualifier sampled on
  // the rising edge; do_checkpoint_o/delete_checkpoint_o answer in the same
  // cycle, recovery outputs are registered and last exactly one cycle.

  rename_ckpt_state_t         state_q;
  logic [CKPT_W-1:0]          head_q, tail_q, rec_label_q;
  logic [CKPT_W:0]            count_q;
  logic [NUM_CHECKPOINTS-1:0] live_q;
  logic                       do_recover_q, flush_q, rec_commit_q;

  logic [CKPT_W-1:0]          head_n, tail_n;
  logic [CKPT_W:0]            count_n;
  logic [NUM_CHECKPOINTS-1:0] live_n;

  logic [CKPT_W-1:0] head_inc, tail_inc, age_l;
  logic              br_older, exc_acc, mp_acc, branch, at_cap, grant, del;

  assign head_inc = head_q + CKPT_W'(1);
  assign tail_inc = tail_q + CKPT_W'(1);
  assign age_l    = br_checkpoint_i - tail_q;

  ckpt_age_cmp #(.CKPT_W(CKPT_W)) u_age_cmp (
    .a     (br_checkpoint_i),
    .b     (rec_label_q),
    .tail  (tail_q),
    .older (br_older)
  );

  assign exc_acc = exc_flush_i & (state_q != ST_EXC_DRAIN) & (state_q != ST_EXC_RECOVER);
  assign mp_acc  = rstn_i & ~exc_acc & br_valid_i & br_mispredict_i & live_q[br_checkpoint_i]
                 & ((state_q == ST_IDLE) | ((state_q == ST_REC_BLANK) & br_older));
  assign branch  = rstn_i & rename_valid_i & rename_is_branch_i & (state_q == ST_IDLE);
  assign at_cap  = count_q == (CKPT_W+1)'(NUM_CHECKPOINTS-1);
  assign grant   = branch & ~at_cap & ~exc_acc & ~mp_acc;
  assign del     = rstn_i & commit_branch_i & (count_q != '0) & (state_q != ST_EXC_RECOVER);

  // Live checkpoints occupy tail+1 .. head; the one freed at commit is tail+1,
  // which then becomes the new tail.
  always_comb begin
    head_n  = head_q;
    tail_n  = tail_q;
    live_n  = live_q;
    count_n = count_q + {{CKPT_W{1'b0}}, grant} - {{CKPT_W{1'b0}}, del};
    if (mp_acc) begin
      for (int i = 0; i < NUM_CHECKPOINTS; i++) begin
        if ((CKPT_W'(i) - tail_q) > age_l) live_n[i] = 1'b0;
      end
    end
    if (del) begin
      live_n[tail_inc] = 1'b0;
      tail_n           = tail_inc;
    end
    if (grant) begin
      live_n[head_inc] = 1'b1;
      head_n           = head_inc;
    end
    if (mp_acc) count_n = {1'b0, br_checkpoint_i - tail_n};
    if (state_q == ST_RECOVER) head_n = rec_label_q;
    if (state_q == ST_EXC_RECOVER) begin
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
      live_n  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      live_q       <= '0;
      rec_label_q  <= '0;
      do_recover_q <= 1'b0;
      flush_q      <= 1'b0;
      rec_commit_q <= 1'b0;
    end else begin
      head_q       <= head_n;
      tail_q       <= tail_n;
      count_q      <= count_n;
      live_q       <= live_n;
      do_recover_q <= 1'b0;
      flush_q      <= 1'b0;
      rec_commit_q <= 1'b0;
      if (exc_acc) begin
        state_q <= ST_EXC_DRAIN;
        flush_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE, ST_REC_BLANK: begin
            if (mp_acc) begin
              state_q      <= ST_RECOVER;
              rec_label_q  <= br_checkpoint_i;
              do_recover_q <= 1'b1;
              flush_q      <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_RECOVER: state_q <= ST_REC_BLANK;
          ST_EXC_DRAIN: begin
            if (rob_empty_i) begin
              state_q      <= ST_EXC_RECOVER;
              rec_commit_q <= 1'b1;
            end
          end
          ST_EXC_RECOVER: state_q <= ST_IDLE;
          default:        state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign do_checkpoint_o      = grant;
  assign ckpt_label_o         = grant ? head_inc : head_q;
  assign delete_checkpoint_o  = del;
  assign stall_rename_o       = rstn_i & ((state_q != ST_IDLE) | (branch & at_cap));
  assign do_recover_o         = do_recover_q;
  assign recover_checkpoint_o = rec_label_q;
  assign flush_front_o        = flush_q;
  assign recover_commit_o     = rec_commit_q;

  // Freeing a checkpoint when none is allocated means the ROB and this
  // mirror have diverged.
  a_commit_with_live : assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(commit_branch_i && (count_q == '0) && (state_q != ST_EXC_RECOVER)))
    else $error("commit_branch_i with no allocated checkpoint");

endmodule
